// File: rtl/uart_regs_mc.sv
// uart_regs_mc: banked UART-side register bank for N_CH ECG channels with per-channel RR FIFOs.
// Optional feature macro UART_REGS_MC_RST_PULSE_EN: CR.rst becomes a self-clearing RST_CYCLES pulse.

module uart_regs_mc #(
    parameter int DATA_W     = 11,
    parameter int N_CH       = 2,
    parameter int RR_DEPTH   = 4,
    parameter int RST_CYCLES = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [3:0]             i_rwaddr,
    input  logic [7:0]             i_write_data,
    input  logic                   i_wr_req,
    input  logic                   i_rd_req,
    output logic [7:0]             o_read_data,
    input  logic [N_CH*DATA_W-1:0] i_rr_period,
    input  logic [N_CH-1:0]        i_rr_vld,
    input  logic [N_CH-1:0]        i_mas_valid,
    input  logic [N_CH-1:0]        i_mal_valid,
    input  logic [N_CH-1:0]        i_th_inited,
    input  logic [N_CH-1:0]        i_alg_active,
    input  logic                   i_tx_fifo_e,
    input  logic                   i_tx_fifo_f,
    input  logic                   i_rx_fifo_e,
    input  logic                   i_rx_fifo_f,
    output logic [DATA_W-1:0]      o_ecg_value,
    output logic [N_CH-1:0]        o_ecg_value_vld,
    output logic [N_CH-1:0]        o_alg_rst,
    output logic [N_CH-1:0]        o_alg_en,
    output logic [N_CH-1:0]        o_src_sel
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int AW    = $clog2(RR_DEPTH);
    localparam int PTR_W = AW + 1;

    localparam logic [3:0] A_CR = 4'd0, A_SR = 4'd1, A_CHSEL = 4'd2, A_DINL = 4'd3, A_DINH = 4'd4,
                           A_DOUTL = 4'd5, A_DOUTH = 4'd6, A_GSR = 4'd7, A_ESR = 4'd8, A_RRCNT = 4'd9;

    if (DATA_W < 9 || DATA_W > 16) begin : g_bad_data_w
        $error("uart_regs_mc: DATA_W must be 9..16");
    end
    if (N_CH < 1 || N_CH > 8) begin : g_bad_n_ch
        $error("uart_regs_mc: N_CH must be 1..8");
    end
    if (RR_DEPTH < 2 || (RR_DEPTH & (RR_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_regs_mc: RR_DEPTH must be a power of two >= 2");
    end
    if (RST_CYCLES < 1) begin : g_bad_rst_cycles
        $error("uart_regs_mc: RST_CYCLES must be >= 1");
    end

    logic [CH_W-1:0]             chsel;
    logic [7:0]                  dinl, shadow, rd_mux;
    logic                        armed;
    logic [N_CH-1:0]             cr_rst, cr_en, cr_src, esr_ovf, esr_udf;
    logic [N_CH-1:0][5:0]        sr_q;
    logic [N_CH-1:0][PTR_W-1:0]  wr_ptr, rd_ptr, occ;
    logic [DATA_W-1:0]           mem [N_CH][RR_DEPTH];
    logic [N_CH-1:0]             empty, full, sel_oh, pop, push_ok, push_drop;
    logic [DATA_W-1:0]           sel_head;
    logic [PTR_W-1:0]            sel_occ;
    logic                        sel_empty;
    logic [2:0]                  sel_cr;
    logic [5:0]                  sel_sr;
    logic [1:0]                  sel_esr;

`ifdef UART_REGS_MC_RST_PULSE_EN
    localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    logic [N_CH-1:0][CNT_W-1:0]  rst_cnt;
`endif

    logic rd_doutl, rd_douth, rd_esr, wr_cr, wr_chsel, wr_dinl, wr_dinh;
    assign rd_doutl = i_rd_req && (i_rwaddr == A_DOUTL);
    assign rd_douth = i_rd_req && (i_rwaddr == A_DOUTH);
    assign rd_esr   = i_rd_req && (i_rwaddr == A_ESR);
    assign wr_cr    = i_wr_req && (i_rwaddr == A_CR);
    assign wr_chsel = i_wr_req && (i_rwaddr == A_CHSEL);
    assign wr_dinl  = i_wr_req && (i_rwaddr == A_DINL);
    assign wr_dinh  = i_wr_req && (i_rwaddr == A_DINH);

    // NOTE: every signal gets a default before the loop so no path leaves it unassigned (no latches).
    always_comb begin
        occ = '0; empty = '0; full = '0; sel_oh = '0; pop = '0; push_ok = '0; push_drop = '0;
        sel_head = '0; sel_occ = '0; sel_empty = 1'b1; sel_cr = '0; sel_sr = '0; sel_esr = '0;
        for (int c = 0; c < N_CH; c++) begin
            occ[c]       = wr_ptr[c] - rd_ptr[c];
            empty[c]     = (occ[c] == '0);
            full[c]      = (occ[c] == PTR_W'(RR_DEPTH));
            sel_oh[c]    = (chsel == CH_W'(c));
            // Armed implies the selected FIFO was non-empty at DOUTL time, so a pop never underflows.
            pop[c]       = rd_douth && armed && sel_oh[c];
            push_ok[c]   = i_rr_vld[c] && (!full[c] || pop[c]);
            push_drop[c] = i_rr_vld[c] && full[c] && !pop[c];
            if (sel_oh[c]) begin
                sel_head  = mem[c][rd_ptr[c][AW-1:0]];
                sel_occ   = occ[c];
                sel_empty = empty[c];
                sel_cr    = {cr_src[c], cr_en[c], cr_rst[c]};
                sel_sr    = sr_q[c];
                sel_esr   = {esr_udf[c], esr_ovf[c]};
            end
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (i_rwaddr)
            A_CR:    rd_mux = {5'b0, sel_cr};
            A_SR:    rd_mux = {2'b0, sel_sr};
            A_CHSEL: rd_mux = 8'(chsel);
            A_DOUTL: rd_mux = sel_empty ? 8'h00 : sel_head[7:0];
            A_DOUTH: rd_mux = shadow;
            A_GSR:   rd_mux = {4'b0, i_rx_fifo_f, i_rx_fifo_e, i_tx_fifo_f, i_tx_fifo_e};
            A_ESR:   rd_mux = {6'b0, sel_esr};
            A_RRCNT: rd_mux = 8'(sel_occ);
            default: rd_mux = 8'h00;
        endcase
    end

    // NOTE: FIFO storage has no reset; the pointers alone define what is valid.
    always_ff @(posedge i_clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (push_ok[c]) mem[c][wr_ptr[c][AW-1:0]] <= i_rr_period[c*DATA_W +: DATA_W];
        end
    end

    // NOTE: state uses non-blocking assignments so every read in this block sees pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_read_data     <= '0;
            o_ecg_value     <= '0;
            o_ecg_value_vld <= '0;
            chsel           <= '0;
            dinl            <= '0;
            shadow          <= '0;
            armed           <= 1'b0;
            cr_rst          <= '0;
            cr_en           <= '0;
            cr_src          <= '0;
            esr_ovf         <= '0;
            esr_udf         <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            for (int c = 0; c < N_CH; c++) sr_q[c] <= 6'h10;
`ifdef UART_REGS_MC_RST_PULSE_EN
            rst_cnt         <= '0;
`endif
        end else begin
            if (i_rd_req) o_read_data <= rd_mux;
            o_ecg_value_vld <= '0;

            for (int c = 0; c < N_CH; c++) begin
                sr_q[c] <= {full[c], empty[c], i_alg_active[c], i_th_inited[c], i_mal_valid[c], i_mas_valid[c]};
                if (push_ok[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
                if (pop[c])     rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);

                // Error flags: a set in the same cycle as a read-to-clear wins.
                if (push_drop[c])                          esr_ovf[c] <= 1'b1;
                else if (rd_esr && sel_oh[c])              esr_ovf[c] <= 1'b0;
                if (rd_doutl && sel_oh[c] && empty[c])     esr_udf[c] <= 1'b1;
                else if (rd_esr && sel_oh[c])              esr_udf[c] <= 1'b0;

                if (wr_cr && sel_oh[c]) begin
                    cr_rst[c] <= i_write_data[0];
                    cr_en[c]  <= i_write_data[1];
                    cr_src[c] <= i_write_data[2];
`ifdef UART_REGS_MC_RST_PULSE_EN
                    rst_cnt[c] <= i_write_data[0] ? CNT_W'(RST_CYCLES - 1) : '0;
                end else if (cr_rst[c]) begin
                    if (rst_cnt[c] == '0) cr_rst[c] <= 1'b0;
                    else                  rst_cnt[c] <= rst_cnt[c] - CNT_W'(1);
`endif
                end
            end

            if (rd_doutl) begin
                shadow <= sel_empty ? 8'h00 : 8'(sel_head >> 8);
                armed  <= !sel_empty;
            end else if (rd_douth) begin
                armed  <= 1'b0;
            end

            // Any CHSEL write abandons a half-read, even when the value itself is rejected.
            if (wr_chsel) begin
                if (i_write_data < 8'(N_CH)) chsel <= CH_W'(i_write_data);
                armed <= 1'b0;
            end

            if (wr_dinl) dinl <= i_write_data;
            if (wr_dinh) begin
                o_ecg_value     <= {i_write_data[DATA_W-9:0], dinl};
                o_ecg_value_vld <= sel_oh;
            end
        end
    end

    assign o_alg_rst = cr_rst;
    assign o_alg_en  = cr_en;
    assign o_src_sel = cr_src;

endmodule

// File: tb/tb_uart_regs_mc.sv
// tb_uart_regs_mc: randomized scoreboard bench for uart_regs_mc against a queue-based register model.
// Works with or without UART_REGS_MC_RST_PULSE_EN defined.

module tb_uart_regs_mc;

    localparam int DATA_W     = 11;
    localparam int N_CH       = 2;
    localparam int RR_DEPTH   = 4;
    localparam int RST_CYCLES = 4;

    logic                   i_clk = 1'b0;
    logic                   i_rst_n;
    logic [3:0]             i_rwaddr;
    logic [7:0]             i_write_data;
    logic                   i_wr_req, i_rd_req;
    logic [7:0]             o_read_data;
    logic [N_CH*DATA_W-1:0] i_rr_period;
    logic [N_CH-1:0]        i_rr_vld, i_mas_valid, i_mal_valid, i_th_inited, i_alg_active;
    logic                   i_tx_fifo_e, i_tx_fifo_f, i_rx_fifo_e, i_rx_fifo_f;
    logic [DATA_W-1:0]      o_ecg_value;
    logic [N_CH-1:0]        o_ecg_value_vld, o_alg_rst, o_alg_en, o_src_sel;

    uart_regs_mc #(.DATA_W(DATA_W), .N_CH(N_CH), .RR_DEPTH(RR_DEPTH), .RST_CYCLES(RST_CYCLES)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rwaddr(i_rwaddr), .i_write_data(i_write_data),
        .i_wr_req(i_wr_req), .i_rd_req(i_rd_req), .o_read_data(o_read_data),
        .i_rr_period(i_rr_period), .i_rr_vld(i_rr_vld),
        .i_mas_valid(i_mas_valid), .i_mal_valid(i_mal_valid), .i_th_inited(i_th_inited),
        .i_alg_active(i_alg_active), .i_tx_fifo_e(i_tx_fifo_e), .i_tx_fifo_f(i_tx_fifo_f),
        .i_rx_fifo_e(i_rx_fifo_e), .i_rx_fifo_f(i_rx_fifo_f),
        .o_ecg_value(o_ecg_value), .o_ecg_value_vld(o_ecg_value_vld),
        .o_alg_rst(o_alg_rst), .o_alg_en(o_alg_en), .o_src_sel(o_src_sel)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit                has_rd;
        logic [3:0]        addr;
        logic [7:0]        rd_val;
        logic [N_CH-1:0]   vld;
        logic [DATA_W-1:0] ecg;
        logic [N_CH-1:0]   arst, en, src;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] last_rd;
    int         n_checks = 0;
    int         n_errors = 0;

    // Behavioural model: plain queues and flags following the register map.
    logic [DATA_W-1:0] m_rr [N_CH][$];
    bit [N_CH-1:0]     m_rst, m_en, m_src, m_ovf, m_udf;
    int                m_left [N_CH];
    int                m_chsel;
    logic [7:0]        m_dinl, m_shadow;
    bit                m_armed;
    logic [7:0]        m_sr [N_CH];
    logic [DATA_W-1:0] m_ecg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_rr[c].delete();
            m_left[c] = 0;
            m_sr[c]   = 8'h10;
        end
        m_rst = '0; m_en = '0; m_src = '0; m_ovf = '0; m_udf = '0;
        m_chsel = 0; m_dinl = '0; m_shadow = '0; m_armed = 1'b0; m_ecg = '0;
    endtask

    // One bus cycle: predict from the pre-edge model state, update the model, drive, advance.
    task automatic step(input bit rd, input bit wr, input logic [3:0] addr, input logic [7:0] wd,
                        input logic [N_CH-1:0] pv, input logic [N_CH*DATA_W-1:0] pvals);
        exp_t              e;
        int                sel;
        logic [3:0]        flags;
        logic [N_CH-1:0]   mas, mal, th, act;
        logic [DATA_W-1:0] head;
        bit                is_empty;
        sel   = m_chsel;
        flags = 4'($urandom);
        mas = N_CH'($urandom); mal = N_CH'($urandom); th = N_CH'($urandom); act = N_CH'($urandom);
        is_empty = (m_rr[sel].size() == 0);
        head = is_empty ? '0 : m_rr[sel][0];

        e.has_rd = rd;
        e.addr   = addr;
        case (addr)
            4'd0:    e.rd_val = {5'd0, m_src[sel], m_en[sel], m_rst[sel]};
            4'd1:    e.rd_val = m_sr[sel];
            4'd2:    e.rd_val = 8'(sel);
            4'd5:    e.rd_val = is_empty ? 8'h00 : head[7:0];
            4'd6:    e.rd_val = m_shadow;
            4'd7:    e.rd_val = {4'd0, flags};
            4'd8:    e.rd_val = {6'd0, m_udf[sel], m_ovf[sel]};
            4'd9:    e.rd_val = 8'(m_rr[sel].size());
            default: e.rd_val = 8'h00;
        endcase

        for (int c = 0; c < N_CH; c++)
            m_sr[c] = {2'b00, m_rr[c].size() == RR_DEPTH, m_rr[c].size() == 0, act[c], th[c], mal[c], mas[c]};

        if (rd && addr == 4'd8) begin
            m_ovf[sel] = 1'b0;
            m_udf[sel] = 1'b0;
        end
        if (rd && addr == 4'd5) begin
            if (is_empty) begin
                m_shadow = 8'h00; m_armed = 1'b0; m_udf[sel] = 1'b1;
            end else begin
                m_shadow = 8'(head >> 8); m_armed = 1'b1;
            end
        end else if (rd && addr == 4'd6 && m_armed) begin
            void'(m_rr[sel].pop_front());
            m_armed = 1'b0;
        end

        for (int c = 0; c < N_CH; c++) begin
            if (pv[c]) begin
                if (m_rr[c].size() < RR_DEPTH) m_rr[c].push_back(pvals[c*DATA_W +: DATA_W]);
                else                           m_ovf[c] = 1'b1;
            end
            if (m_left[c] > 0) m_left[c]--;
        end

        e.vld = '0;
        if (wr) begin
            case (addr)
                4'd0: begin
                    m_rst[sel] = wd[0]; m_en[sel] = wd[1]; m_src[sel] = wd[2];
                    m_left[sel] = wd[0] ? RST_CYCLES : 0;
                end
                4'd2: begin
                    if (wd < N_CH) m_chsel = int'(wd);
                    m_armed = 1'b0;
                end
                4'd3: m_dinl = wd;
                4'd4: begin
                    m_ecg = {wd[DATA_W-9:0], m_dinl};
                    e.vld = N_CH'(1) << sel;
                end
                default: ;
            endcase
        end
`ifdef UART_REGS_MC_RST_PULSE_EN
        for (int c = 0; c < N_CH; c++) m_rst[c] = (m_left[c] > 0);
`endif
        e.ecg = m_ecg; e.arst = m_rst; e.en = m_en; e.src = m_src;

        i_rd_req = rd; i_wr_req = wr; i_rwaddr = addr; i_write_data = wd;
        i_rr_vld = pv; i_rr_period = pvals;
        i_mas_valid = mas; i_mal_valid = mal; i_th_inited = th; i_alg_active = act;
        {i_rx_fifo_f, i_rx_fifo_e, i_tx_fifo_f, i_tx_fifo_e} = flags;
        exp_q.push_back(e);
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic rdreg(input logic [3:0] a);  step(1'b1, 1'b0, a, 8'h00, '0, '0); endtask
    task automatic wrreg(input logic [3:0] a, input logic [7:0] d); step(1'b0, 1'b1, a, d, '0, '0); endtask
    task automatic idle(input int n); for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 8'h00, '0, '0); endtask

    task automatic push1(input int ch, input logic [DATA_W-1:0] v, input bit rd, input logic [3:0] a);
        logic [N_CH-1:0]        pv;
        logic [N_CH*DATA_W-1:0] pvals;
        pv = '0; pvals = '0;
        pv[ch] = 1'b1;
        pvals[ch*DATA_W +: DATA_W] = v;
        step(rd, 1'b0, a, 8'h00, pv, pvals);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_rd_req = 1'b0; i_wr_req = 1'b0; i_rr_vld = '0;
        #1;
        check("rst_read_data", o_read_data, 8'h00);
        check("rst_ecg_value", o_ecg_value, '0);
        check("rst_ecg_vld", o_ecg_value_vld, '0);
        check("rst_alg_rst", o_alg_rst, '0);
        check("rst_alg_en", o_alg_en, '0);
        check("rst_src_sel", o_src_sel, '0);
        exp_q.delete();
        model_reset();
        last_rd = 8'h00;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    // Monitor: one expectation per bus cycle, compared just after the active edge.
    always @(posedge i_clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.has_rd) last_rd = mon_e.rd_val;
            check($sformatf("read_data@%0d", mon_e.addr), o_read_data, last_rd);
            check("ecg_vld", o_ecg_value_vld, mon_e.vld);
            check("ecg_value", o_ecg_value, mon_e.ecg);
            check("alg_rst", o_alg_rst, mon_e.arst);
            check("alg_en", o_alg_en, mon_e.en);
            check("src_sel", o_src_sel, mon_e.src);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst_n = 1'b0; i_rwaddr = '0; i_write_data = '0; i_wr_req = 1'b0; i_rd_req = 1'b0;
        i_rr_period = '0; i_rr_vld = '0; i_mas_valid = '0; i_mal_valid = '0; i_th_inited = '0;
        i_alg_active = '0; {i_tx_fifo_e, i_tx_fifo_f, i_rx_fifo_e, i_rx_fifo_f} = 4'b1010;
        last_rd = 8'h00;
        model_reset();
        @(negedge i_clk);
        do_reset();

        // Reset values across the whole map.
        for (int a = 0; a < 10; a++) rdreg(4'(a));

        // Sample commit on channel 1, then DINL retention.
        wrreg(4'd2, 8'd1); wrreg(4'd3, 8'hAB); wrreg(4'd4, 8'h05); idle(2);
        wrreg(4'd4, 8'h02); rdreg(4'd3);

        // Two-byte RR readout order on channel 0.
        wrreg(4'd2, 8'd0);
        push1(0, 11'h3FF, 1'b0, 4'd0); push1(0, 11'h123, 1'b0, 4'd0);
        rdreg(4'd1); rdreg(4'd5); rdreg(4'd6); rdreg(4'd9); rdreg(4'd5); rdreg(4'd6); rdreg(4'd9);

        // Overflow, read-to-clear, drain and underflow.
        for (int i = 0; i < 5; i++) push1(0, DATA_W'($urandom), 1'b0, 4'd0);
        rdreg(4'd1); rdreg(4'd9); rdreg(4'd8); rdreg(4'd8);
        repeat (RR_DEPTH) begin rdreg(4'd5); rdreg(4'd6); end
        rdreg(4'd5); rdreg(4'd6); rdreg(4'd8); rdreg(4'd8);

        // A CHSEL write cancels a half-read; out-of-range CHSEL is ignored.
        push1(0, 11'h4C7, 1'b0, 4'd0);
        rdreg(4'd5); wrreg(4'd2, 8'd0); rdreg(4'd6); rdreg(4'd9);
        wrreg(4'd2, 8'd7); rdreg(4'd2); wrreg(4'd2, 8'd1); rdreg(4'd2);

        // CR behaviour: pulse or level, restart and abort.
        wrreg(4'd0, 8'h01); idle(RST_CYCLES + 2); rdreg(4'd0);
        wrreg(4'd0, 8'h06); rdreg(4'd0); wrreg(4'd0, 8'h00);
        wrreg(4'd0, 8'h01); idle(2); wrreg(4'd0, 8'h01); idle(2); wrreg(4'd0, 8'h00); rdreg(4'd0);

        // Channel 1: push while full with a simultaneous pop is accepted.
        for (int i = 0; i < RR_DEPTH; i++) push1(1, DATA_W'($urandom), 1'b0, 4'd0);
        rdreg(4'd5); push1(1, 11'h7FE, 1'b1, 4'd6);
        rdreg(4'd8); rdreg(4'd9);
        repeat (RR_DEPTH) begin rdreg(4'd5); rdreg(4'd6); end

        // Same-cycle pushes on both channels, then read-during-write on CHSEL.
        step(1'b0, 1'b0, 4'd0, 8'h00, 2'b11, {11'h155, 11'h2AA});
        rdreg(4'd9); step(1'b1, 1'b1, 4'd2, 8'd0, '0, '0); rdreg(4'd9); rdreg(4'd2);

        // ESR set wins over a same-cycle read-to-clear.
        for (int i = 0; i < RR_DEPTH; i++) push1(0, DATA_W'($urandom), 1'b0, 4'd0);
        push1(0, 11'h001, 1'b1, 4'd8); rdreg(4'd8); rdreg(4'd8);

        // Reset in the middle of a pulse and a half-read.
        wrreg(4'd0, 8'h03); rdreg(4'd5);
        do_reset();
        rdreg(4'd6); rdreg(4'd9); rdreg(4'd0); rdreg(4'd8);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit                     rd, wr;
            logic [3:0]             a;
            logic [7:0]             d;
            logic [N_CH-1:0]        pv;
            rd = ($urandom_range(0, 2) != 0);
            wr = ($urandom_range(0, 3) == 0);
            a  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 9));
            d  = (a == 4'd2) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            pv = ($urandom_range(0, 2) == 0) ? N_CH'($urandom) : '0;
            step(rd, wr, a, d, pv, (N_CH*DATA_W)'({$urandom, $urandom}));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_regs_mc.md
Name: uart_regs_mc

Overview:
- Multi-channel, width-parametrised UART-side register bank between the UART byte protocol engine and N_CH ECG processing channels.
- Host selects a channel via CHSEL; CR/SR/ESR/RR registers are banked per channel.
- Host writes ECG samples as two bytes, committed atomically to the selected channel.
- RR-period results are buffered per channel in a small FIFO with atomic two-byte readout, so no result is lost between host polls.

Parameters:
- DATA_W, 11, sample/RR width; legal 9..16.
- N_CH, 2, channel count; legal 1..8.
- RR_DEPTH, 4, per-channel RR FIFO depth; power of two, at least 2.
- RST_CYCLES, 4, o_alg_rst pulse length when UART_REGS_MC_RST_PULSE_EN is defined; at least 1.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_rwaddr  in  4  register offset
- i_write_data  in  8  write byte
- i_wr_req  in  1  write strobe, one cycle per access
- i_rd_req  in  1  read strobe, one cycle per access
- o_read_data  out  8  registered read data
- i_rr_period  in  N_CH*DATA_W  per-channel RR value; channel c occupies [c*DATA_W +: DATA_W]
- i_rr_vld  in  N_CH  push strobe per channel
- i_mas_valid, i_mal_valid, i_th_inited, i_alg_active  in  N_CH each  per-channel status
- i_tx_fifo_e, i_tx_fifo_f, i_rx_fifo_e, i_rx_fifo_f  in  1 each  UART FIFO flags
- o_ecg_value  out  DATA_W  committed sample, shared by all channels
- o_ecg_value_vld  out  N_CH  one-cycle one-hot commit pulse
- o_alg_rst, o_alg_en, o_src_sel  out  N_CH each  per-channel control

Behaviour:
Register map (unmapped or reserved bits read 0; unmapped writes ignored):
- 0 CR, banked: [0] rst, [1] en, [2] src_sel.
- 1 SR, banked, read-only: [0] ma_s_vld, [1] ma_l_vld, [2] th_inited, [3] alg_active, [4] rr_empty, [5] rr_full. Snapshot registered every cycle.
- 2 CHSEL: writes of a value >= N_CH are ignored. Reads return the current value. When N_CH=1, CHSEL always reads 0.
- 3 DINL: write-only staging byte.
- 4 DINH: a write commits the sample. o_ecg_value <= {i_write_data[DATA_W-9:0], DINL}. o_ecg_value_vld[CHSEL] is high for exactly the next cycle. DINL is retained.
- 5 DOUTL: read returns head[7:0] of the selected FIFO. It latches head[DATA_W-1:8] into a shadow byte and sets armed.
- 6 DOUTH: read returns the shadow byte. If armed: pop the FIFO and clear armed.
- 7 GSR, read-only: [0] tx_e, [1] tx_f, [2] rx_e, [3] rx_f.
- 8 ESR, banked: [0] rr_ovf, [1] rr_udf. Read-to-clear on the selected channel. If a set and a clear occur in the same cycle, the set wins.
- 9 RRCNT: occupancy of the selected FIFO, 0..RR_DEPTH.

Read timing and write/read interaction:
- Read latency is 1 cycle. o_read_data holds its value when i_rd_req is low.
- Simultaneous i_rd_req and i_wr_req: both are performed, and the read returns the pre-write value.

RR FIFO boundaries:
- Push when full: the sample is dropped and rr_ovf is set.
- Push and pop on the same cycle while full: both are performed, occupancy is unchanged, rr_ovf is not set.
- DOUTL read when empty: returns 0x00, shadow is set to 0, armed stays 0, rr_udf is set.
- DOUTH read when not armed: returns the shadow byte, no pop.
- A CHSEL write (accepted or ignored) clears armed.
- Pushes on different channels in the same cycle are all accepted.

Reset (asynchronous, active-low):
- All registers, shadow, armed and FIFOs clear. FIFOs read empty.
- o_read_data = 0, o_ecg_value = 0, o_ecg_value_vld = 0, o_alg_rst = 0, o_alg_en = 0, o_src_sel = 0.
- Reset mid-operation abandons pending pulses and any half-read.

Optional Feature:
UART_REGS_MC_RST_PULSE_EN
- Defined: writing CR with rst=1 loads a per-channel counter. o_alg_rst[ch] stays high for exactly RST_CYCLES cycles, then CR.rst self-clears and reads 0.
  - Rewriting rst=1 during the pulse restarts the count.
  - Writing rst=0 during the pulse aborts it.
- Undefined: CR.rst is a plain level bit and o_alg_rst follows it.

Test Plan:
- Reset, then read offsets 0..9 -> all reads 0x00 except SR (rr_empty=1, 0x10) and GSR, which reflects the input flags.
- CHSEL=1; write DINL=0xAB; write DINH=0x05 -> o_ecg_value=0x5AB and o_ecg_value_vld=2'b10 for exactly 1 cycle.
- Push 0x3FF, then 0x123 on ch0 -> DOUTL=0xFF, DOUTH=0x03, RRCNT=1; DOUTL=0x23, DOUTH=0x01, RRCNT=0.
- Push 5 values into a depth-4 FIFO -> 5th value dropped; ESR read=0x01, second ESR read=0x00. DOUTL on an empty FIFO returns 0x00 and ESR then reads 0x02.
- DOUTL read, then a CHSEL write, then a DOUTH read -> no pop, RRCNT unchanged. A CHSEL write of 7 (N_CH=2) -> CHSEL unchanged.
- With the macro defined, write CR=0x01 -> o_alg_rst high for 4 cycles, then CR reads 0x00. Without the macro -> o_alg_rst stays high until CR=0x00 is written.
